// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core with on-the-fly key expansion.
//
// One round is computed per clock. The round key is expanded from the previous
// round key in the same cycle, so no key schedule is stored.
//
// Byte i of every 128-bit word sits in bits [8i+7:8i] and maps to state
// row i%4, column i/4.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous, active-high reset
//   i_start        pulse to start an encryption (ignored while busy)
//   i_key          128-bit cipher key, sampled on an accepted start
//   i_plain_text   128-bit plaintext, sampled on an accepted start
//   o_cipher_text  registered ciphertext, held until the next completion
//   o_busy         high while rounds are in progress
//   o_done         one-cycle pulse when o_cipher_text is updated

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_q
);
  // FIPS-197 S-box; entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_idx;

  assign w_idx = 11'd2047 - {i_a, 3'b000};
  assign o_q   = SBOX[w_idx -: 8];
endmodule

// States:
//   state  | meaning
//   S_IDLE | waiting for i_start; o_busy low
//   S_RUN  | rounds 1..10 in progress, one per clock
module aes_top (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic [127:0] i_plain_text,
  output logic [127:0] o_cipher_text,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t       r_fsm;
  state_t       w_fsm_next;
  logic         w_accept;
  logic         w_last;

  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic [127:0] r_cipher;
  logic         r_done;

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [31:0]  w_subword;
  logic [7:0]   w_rcon;
  logic [31:0]  w_temp;
  logic [127:0] w_rk_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (i_start) begin
          w_accept   = 1'b1;
          w_fsm_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_round == 4'd10) begin
          w_last     = 1'b1;
          w_fsm_next = S_IDLE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- round datapath
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .i_a (r_state[8*i +: 8]),
      .o_q (w_sb[8*i +: 8])
    );
  end

  // Output row r, column c takes input row r, column (c+r)%4.
  for (genvar r = 0; r < 4; r++) begin : g_shift_row
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
      assign w_sr[8*(r+4*c) +: 8] = w_sb[8*(r+4*((c+r)%4)) +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix_col
    assign w_mc[32*c +: 32] = mix_col(w_sr[32*c +: 32]);
  end

  // ------------------------------------------------------ key expansion
  // SubWord(RotWord(w3)): RotWord moves byte 13 into the first position.
  aes_sbox u_ksbox0 (.i_a(r_rk[111:104]), .o_q(w_subword[7:0]));
  aes_sbox u_ksbox1 (.i_a(r_rk[119:112]), .o_q(w_subword[15:8]));
  aes_sbox u_ksbox2 (.i_a(r_rk[127:120]), .o_q(w_subword[23:16]));
  aes_sbox u_ksbox3 (.i_a(r_rk[103:96]),  .o_q(w_subword[31:24]));

  always_comb begin
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Rcon lands on the first byte of the word, i.e. its least significant byte.
  assign w_temp              = w_subword ^ {24'h000000, w_rcon};
  assign w_rk_next[31:0]     = r_rk[31:0]   ^ w_temp;
  assign w_rk_next[63:32]    = r_rk[63:32]  ^ w_rk_next[31:0];
  assign w_rk_next[95:64]    = r_rk[95:64]  ^ w_rk_next[63:32];
  assign w_rk_next[127:96]   = r_rk[127:96] ^ w_rk_next[95:64];

  // ------------------------------------------------------ state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= '0;
      r_rk     <= '0;
      r_round  <= 4'd0;
      r_cipher <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= i_plain_text ^ i_key;
        r_rk    <= i_key;
        r_round <= 4'd1;
      end else if (r_fsm == S_RUN) begin
        r_rk <= w_rk_next;
        if (w_last) begin
          // Final round skips MixColumns.
          r_cipher <= w_sr ^ w_rk_next;
          r_done   <= 1'b1;
          r_round  <= 4'd0;
        end else begin
          r_state <= w_mc ^ w_rk_next;
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

  assign o_cipher_text = r_cipher;
  assign o_busy        = (r_fsm == S_RUN);
  assign o_done        = r_done;

endmodule

// File: tb/tb_aes_top.sv
// tb_aes_top: directed-vector bench for aes_top using the FIPS-197 C.1 and
// Appendix B vectors, plus reset, ignore-while-busy, back-to-back and hold cases.

module tb_aes_top;

  localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] P1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] K2 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] P2 = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] C2 = 128'h320b6a19978511dcfb09dc021d842539;

  logic         i_clk;
  logic         i_rst;
  logic         i_start;
  logic [127:0] i_key;
  logic [127:0] i_plain_text;
  logic [127:0] o_cipher_text;
  logic         o_busy;
  logic         o_done;

  int n_checks;
  int n_errors;

  aes_top dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_key         (i_key),
    .i_plain_text  (i_plain_text),
    .o_cipher_text (o_cipher_text),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive start for exactly one edge; returns just after the accepting edge.
  task automatic start_enc(input logic [127:0] k, input logic [127:0] p);
    i_key        = k;
    i_plain_text = p;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
  endtask

  // Counts edges after the start edge until o_done; -1 if it never comes.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (o_done) begin
        cycles = n;
        break;
      end
    end
  endtask

  initial begin
    int  cyc;
    int  pulses;
    int  first_at;
    logic [127:0] seen;
    logic seen_done;

    n_checks     = 0;
    n_errors     = 0;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_key        = '0;
    i_plain_text = '0;
    tick();
    tick();
    check_eq("reset_cipher", o_cipher_text, 128'd0);
    check_eq("reset_busy", {127'd0, o_busy}, 128'd0);
    check_eq("reset_done", {127'd0, o_done}, 128'd0);
    i_rst = 1'b0;
    tick();

    // FIPS C.1
    start_enc(K1, P1);
    check_eq("c1_busy", {127'd0, o_busy}, 128'd1);
    i_key        = '1;
    i_plain_text = '0;
    wait_done(cyc);
    check_eq("c1_latency", 128'(cyc), 128'd10);
    check_eq("c1_cipher", o_cipher_text, C1);
    check_eq("c1_busy_low", {127'd0, o_busy}, 128'd0);
    tick();
    check_eq("c1_done_one_cycle", {127'd0, o_done}, 128'd0);

    // FIPS Appendix B
    start_enc(K2, P2);
    wait_done(cyc);
    check_eq("b_latency", 128'(cyc), 128'd10);
    check_eq("b_cipher", o_cipher_text, C2);
    tick();

    // Second start 3 cycles into a C.1 run must be ignored.
    start_enc(K1, P1);
    tick();
    tick();
    start_enc(K2, P2);
    pulses   = 0;
    first_at = -1;
    seen     = '0;
    for (int n = 4; n <= 25; n++) begin
      if (o_done) begin
        pulses++;
        if (first_at < 0) begin
          first_at = n - 1;
          seen     = o_cipher_text;
        end
      end
      tick();
    end
    check_eq("ignore_pulses", 128'(pulses), 128'd1);
    check_eq("ignore_latency", 128'(first_at), 128'd10);
    check_eq("ignore_cipher", seen, C1);

    // Back-to-back: next start driven while done is high.
    start_enc(K1, P1);
    wait_done(cyc);
    check_eq("b2b_first_latency", 128'(cyc), 128'd10);
    check_eq("b2b_first_cipher", o_cipher_text, C1);
    start_enc(K2, P2);
    check_eq("b2b_second_busy", {127'd0, o_busy}, 128'd1);
    check_eq("b2b_first_held", o_cipher_text, C1);
    wait_done(cyc);
    check_eq("b2b_second_latency", 128'(cyc), 128'd10);
    check_eq("b2b_second_cipher", o_cipher_text, C2);

    // Hold: inputs change with no start.
    i_key        = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    i_plain_text = 128'h0badc0de_11111111_22222222_33333333;
    tick();
    seen_done = 1'b0;
    for (int n = 0; n < 6; n++) begin
      seen_done |= o_done;
      tick();
    end
    check_eq("hold_cipher", o_cipher_text, C2);
    check_eq("hold_no_done", {127'd0, seen_done}, 128'd0);
    check_eq("hold_idle", {127'd0, o_busy}, 128'd0);

    // Reset mid-encryption.
    start_enc(K1, P1);
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    check_eq("midrst_cipher", o_cipher_text, 128'd0);
    check_eq("midrst_busy", {127'd0, o_busy}, 128'd0);
    check_eq("midrst_done", {127'd0, o_done}, 128'd0);
    seen_done = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      seen_done |= o_done;
    end
    check_eq("midrst_no_done", {127'd0, seen_done}, 128'd0);
    check_eq("midrst_cipher_after", o_cipher_text, 128'd0);

    // Recovery after reset.
    start_enc(K2, P2);
    wait_done(cyc);
    check_eq("recover_latency", 128'(cyc), 128'd10);
    check_eq("recover_cipher", o_cipher_text, C2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
